// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: launches NUM_CORES decryptors per batch over [start_key, end_key],
// masks the partial last batch, reports the lowest-index winner and counts keys fully rejected.
module rc4_key_search_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int KEY_WIDTH  = 24,
  parameter int CORE_IDX_W = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [KEY_WIDTH-1:0]           start_key,
  input  logic [KEY_WIDTH-1:0]           end_key,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_fail,
  output logic                           busy,
  output logic                           found,
  output logic                           not_found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [CORE_IDX_W-1:0]          found_core,
  output logic [KEY_WIDTH:0]             keys_tried
);

  localparam int KW1 = KEY_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t                  state_q, state_d;
  logic [KEY_WIDTH-1:0]    base_q, base_d;
  logic [KEY_WIDTH-1:0]    end_q, end_d;
  logic [NUM_CORES-1:0]    core_start_q, core_start_d;
  logic [NUM_CORES-1:0]    active_q, active_d;
  logic [KEY_WIDTH-1:0]    found_key_q, found_key_d;
  logic [CORE_IDX_W-1:0]   found_core_q, found_core_d;
  logic [KW1-1:0]          keys_tried_q, keys_tried_d;

  logic [NUM_CORES-1:0]    hit;
  logic                    all_fail;
  logic [CORE_IDX_W-1:0]   win_idx;
  logic [KW1-1:0]          active_cnt;
  logic [KW1-1:0]          base_next;

  // Compare in KEY_WIDTH+1 bits so keys near the top of the space never wrap to 0.
  function automatic logic [NUM_CORES-1:0] active_mask(input logic [KEY_WIDTH-1:0] b,
                                                       input logic [KEY_WIDTH-1:0] e);
    logic [NUM_CORES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      m[i] = (({1'b0, b} + KW1'(i)) <= {1'b0, e});
    end
    return m;
  endfunction

  always_comb begin
    hit      = core_done & active_q;
    all_fail = &(core_fail | ~active_q);

    win_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx = CORE_IDX_W'(i);
      end
    end

    active_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      active_cnt = active_cnt + KW1'(active_q[i]);
    end

    base_next = {1'b0, base_q} + KW1'(NUM_CORES);
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    end_d        = end_q;
    core_start_d = '0;
    active_d     = active_q;
    found_key_d  = found_key_q;
    found_core_d = found_core_q;
    keys_tried_d = keys_tried_q;

    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          base_d       = start_key;
          end_d        = end_key;
          keys_tried_d = '0;
          if (start_key > end_key) begin
            state_d  = S_EXHAUSTED;
            active_d = '0;
          end else begin
            state_d      = S_LAUNCH;
            active_d     = active_mask(start_key, end_key);
            core_start_d = active_d;
          end
        end
      end

      S_LAUNCH: begin
        state_d = abort ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (|hit) begin
          state_d      = S_FOUND;
          found_core_d = win_idx;
          found_key_d  = base_q + KEY_WIDTH'(win_idx);
        end else if (all_fail) begin
          state_d = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          keys_tried_d = keys_tried_q + active_cnt;
          if (base_next > {1'b0, end_q}) begin
            state_d = S_EXHAUSTED;
          end else begin
            state_d      = S_LAUNCH;
            base_d       = base_next[KEY_WIDTH-1:0];
            active_d     = active_mask(base_d, end_q);
            core_start_d = active_d;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      end_q        <= '0;
      core_start_q <= '0;
      active_q     <= '0;
      found_key_q  <= '0;
      found_core_q <= '0;
      keys_tried_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      end_q        <= end_d;
      core_start_q <= core_start_d;
      active_q     <= active_d;
      found_key_q  <= found_key_d;
      found_core_q <= found_core_d;
      keys_tried_q <= keys_tried_d;
    end
  end

  // The launch pulse is suppressed in the cycle an abort is raised.
  assign core_start = core_start_q & ~{NUM_CORES{abort}};

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      core_key[i*KEY_WIDTH +: KEY_WIDTH] = base_q + KEY_WIDTH'(i);
    end
  end

  assign busy       = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_ADVANCE);
  assign found      = (state_q == S_FOUND);
  assign not_found  = (state_q == S_EXHAUSTED);
  assign found_key  = found_key_q;
  assign found_core = found_core_q;
  assign keys_tried = keys_tried_q;

endmodule
